// File: rtl/smc_ahb_arbiter1_pkg.sv
// Shared AHB encodings, arbiter FSM states and the tie-break helper
// used by the two-master SMC arbiter.
package smc_ahb_arbiter1_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // Only NONSEQ/SEQ carry a transfer; BUSY and IDLE are ignored.
  function automatic logic htrans_is_xfer(input logic [1:0] t);
    logic r;
    case (t)
      HTRANS_NONSEQ, HTRANS_SEQ: r = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  r = 1'b0;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

  // Returns 1 when m1 should be granted.
  function automatic logic pick_m1(input logic req0, input logic req1,
                                   input logic last_m1, input logic fixed_prio);
    logic r;
    if (req0 && req1) r = fixed_prio ? 1'b0 : ~last_m1;
    else              r = req1;
    return r;
  endfunction

endpackage

// File: rtl/smc_ahb_arbiter1_hold.sv
// Per-master address-phase capture: hold registers, pending flag and the
// master-facing hready/hresp/hrdata gating.
module smc_arb_hold1
  import smc_ahb_arbiter1_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              data_phase,
  input  logic              smc_hready,
  input  logic [1:0]        smc_hresp,
  input  logic [DATA_W-1:0] smc_hrdata,
  output logic              pend,
  output logic              capture,
  output logic [ADDR_W-1:0] addr_q,
  output logic              write_q,
  output logic [2:0]        size_q,
  output logic              hready,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata
);

  logic done;

  // While this master owns the SMC data phase the SMC response is forwarded;
  // otherwise a pending master is simply stalled with an OKAY response.
  assign hready  = data_phase ? smc_hready : ~pend;
  assign hresp   = data_phase ? smc_hresp  : HRESP_OKAY;
  assign hrdata  = data_phase ? smc_hrdata : '0;
  assign done    = data_phase & smc_hready;
  assign capture = hsel & htrans_is_xfer(htrans) & hready;

  // A capture in the completion cycle re-arms pend rather than clearing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else if (capture) begin
      pend    <= 1'b1;
      addr_q  <= haddr;
      write_q <= hwrite;
      size_q  <= hsize;
    end else if (done) begin
      pend    <= 1'b0;
    end
  end

endmodule

// File: rtl/smc_ahb_arbiter1.sv
// Two-master AHB-lite arbiter in front of the SMC slave port: captures each
// master's address phase, arbitrates, and replays the transfer to the SMC.
module smc_ahb_arbiter1
  import smc_ahb_arbiter1_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              hclk1,
  input  logic              n_sys_reset1,
  input  logic              m0_hsel1,
  input  logic [ADDR_W-1:0] m0_haddr1,
  input  logic [1:0]        m0_htrans1,
  input  logic              m0_hwrite1,
  input  logic [2:0]        m0_hsize1,
  input  logic [DATA_W-1:0] m0_hwdata1,
  output logic [DATA_W-1:0] m0_hrdata1,
  output logic              m0_hready1,
  output logic [1:0]        m0_hresp1,
  input  logic              m1_hsel1,
  input  logic [ADDR_W-1:0] m1_haddr1,
  input  logic [1:0]        m1_htrans1,
  input  logic              m1_hwrite1,
  input  logic [2:0]        m1_hsize1,
  input  logic [DATA_W-1:0] m1_hwdata1,
  output logic [DATA_W-1:0] m1_hrdata1,
  output logic              m1_hready1,
  output logic [1:0]        m1_hresp1,
  output logic              smc_hsel1,
  output logic [ADDR_W-1:0] smc_haddr1,
  output logic [1:0]        smc_htrans1,
  output logic              smc_hwrite1,
  output logic [2:0]        smc_hsize1,
  output logic [DATA_W-1:0] smc_hwdata1,
  output logic              smc_hready_in1,
  input  logic [DATA_W-1:0] smc_hrdata1,
  input  logic              smc_hready1,
  input  logic [1:0]        smc_hresp1,
  output logic [1:0]        arb_grant1
);

  arb_state_e state_reg, state_next;
  logic       owner_reg, owner_next;
  logic       last_m1_reg, last_m1_next;

  logic [1:0]        m_hsel, m_hwrite, pend, capture, req, hready, data_phase, write_q;
  logic [1:0]        m_htrans [2];
  logic [1:0]        hresp    [2];
  logic [2:0]        m_hsize  [2];
  logic [2:0]        size_q   [2];
  logic [ADDR_W-1:0] m_haddr  [2];
  logic [ADDR_W-1:0] addr_q   [2];
  logic [DATA_W-1:0] m_hwdata [2];
  logic [DATA_W-1:0] hrdata   [2];

  assign m_hsel      = {m1_hsel1, m0_hsel1};
  assign m_hwrite    = {m1_hwrite1, m0_hwrite1};
  assign m_htrans[0] = m0_htrans1;
  assign m_htrans[1] = m1_htrans1;
  assign m_hsize[0]  = m0_hsize1;
  assign m_hsize[1]  = m1_hsize1;
  assign m_haddr[0]  = m0_haddr1;
  assign m_haddr[1]  = m1_haddr1;
  assign m_hwdata[0] = m0_hwdata1;
  assign m_hwdata[1] = m1_hwdata1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_hold
    assign data_phase[gi] = (state_reg == ST_DATA) && (owner_reg == 1'(gi));

    smc_arb_hold1 #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_hold (
      .clk        (hclk1),
      .rst_n      (n_sys_reset1),
      .hsel       (m_hsel[gi]),
      .haddr      (m_haddr[gi]),
      .htrans     (m_htrans[gi]),
      .hwrite     (m_hwrite[gi]),
      .hsize      (m_hsize[gi]),
      .data_phase (data_phase[gi]),
      .smc_hready (smc_hready1),
      .smc_hresp  (smc_hresp1),
      .smc_hrdata (smc_hrdata1),
      .pend       (pend[gi]),
      .capture    (capture[gi]),
      .addr_q     (addr_q[gi]),
      .write_q    (write_q[gi]),
      .size_q     (size_q[gi]),
      .hready     (hready[gi]),
      .hresp      (hresp[gi]),
      .hrdata     (hrdata[gi])
    );
  end

  // A capture in the current cycle counts as a request so an uncontended
  // transfer reaches the SMC address phase one cycle after the master issues it.
  assign req = pend | capture;

  always_ff @(posedge hclk1 or negedge n_sys_reset1) begin
    if (!n_sys_reset1) begin
      state_reg   <= ST_IDLE;
      owner_reg   <= 1'b0;
      last_m1_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      last_m1_reg <= last_m1_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    last_m1_next = last_m1_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          owner_next = pick_m1(req[0], req[1], last_m1_reg, FIXED_PRIO != 0);
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (smc_hready1) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (smc_hready1) begin
          last_m1_next = owner_reg;
          if (req[~owner_reg]) begin
            owner_next = ~owner_reg;
            state_next = ST_ADDR;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // SEQ from a master is always replayed as NONSEQ: each transfer stands alone.
  always_comb begin
    smc_hsel1   = 1'b0;
    smc_htrans1 = HTRANS_IDLE;
    smc_haddr1  = '0;
    smc_hwrite1 = 1'b0;
    smc_hsize1  = '0;
    smc_hwdata1 = '0;
    arb_grant1  = 2'b00;
    case (state_reg)
      ST_ADDR: begin
        smc_hsel1   = 1'b1;
        smc_htrans1 = HTRANS_NONSEQ;
        smc_haddr1  = addr_q[owner_reg];
        smc_hwrite1 = write_q[owner_reg];
        smc_hsize1  = size_q[owner_reg];
        arb_grant1  = owner_reg ? 2'b10 : 2'b01;
      end
      ST_DATA: begin
        smc_haddr1  = addr_q[owner_reg];
        smc_hwrite1 = write_q[owner_reg];
        smc_hsize1  = size_q[owner_reg];
        smc_hwdata1 = m_hwdata[owner_reg];
        arb_grant1  = owner_reg ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  assign smc_hready_in1 = smc_hready1;

  assign m0_hready1 = hready[0];
  assign m0_hresp1  = hresp[0];
  assign m0_hrdata1 = hrdata[0];
  assign m1_hready1 = hready[1];
  assign m1_hresp1  = hresp[1];
  assign m1_hrdata1 = hrdata[1];

endmodule

// File: tb/tb_smc_ahb_arbiter1.sv
// Directed bench for the two-master SMC arbiter; a second instance with
// fixed priority shares the stimulus for the tie-break comparison.
module tb_smc_ahb_arbiter1;
  import smc_ahb_arbiter1_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_sys_reset1;
  logic          m0_hsel1, m0_hwrite1, m1_hsel1, m1_hwrite1;
  logic [AW-1:0] m0_haddr1, m1_haddr1;
  logic [1:0]    m0_htrans1, m1_htrans1;
  logic [2:0]    m0_hsize1, m1_hsize1;
  logic [DW-1:0] m0_hwdata1, m1_hwdata1;
  logic [DW-1:0] smc_hrdata1;
  logic          smc_hready1;
  logic [1:0]    smc_hresp1;

  logic [DW-1:0] m0_hrdata1, m1_hrdata1, smc_hwdata1;
  logic          m0_hready1, m1_hready1, smc_hsel1, smc_hwrite1, smc_hready_in1;
  logic [1:0]    m0_hresp1, m1_hresp1, smc_htrans1, arb_grant1;
  logic [AW-1:0] smc_haddr1;
  logic [2:0]    smc_hsize1;

  logic [DW-1:0] fp_m0_hrdata1, fp_m1_hrdata1, fp_smc_hwdata1;
  logic          fp_m0_hready1, fp_m1_hready1, fp_smc_hsel1, fp_smc_hwrite1, fp_smc_hready_in1;
  logic [1:0]    fp_m0_hresp1, fp_m1_hresp1, fp_smc_htrans1, fp_arb_grant1;
  logic [AW-1:0] fp_smc_haddr1;
  logic [2:0]    fp_smc_hsize1;

  int checks = 0;
  int errors = 0;

  smc_ahb_arbiter1 #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
    .hclk1(clk), .n_sys_reset1(n_sys_reset1),
    .m0_hsel1(m0_hsel1), .m0_haddr1(m0_haddr1), .m0_htrans1(m0_htrans1),
    .m0_hwrite1(m0_hwrite1), .m0_hsize1(m0_hsize1), .m0_hwdata1(m0_hwdata1),
    .m0_hrdata1(m0_hrdata1), .m0_hready1(m0_hready1), .m0_hresp1(m0_hresp1),
    .m1_hsel1(m1_hsel1), .m1_haddr1(m1_haddr1), .m1_htrans1(m1_htrans1),
    .m1_hwrite1(m1_hwrite1), .m1_hsize1(m1_hsize1), .m1_hwdata1(m1_hwdata1),
    .m1_hrdata1(m1_hrdata1), .m1_hready1(m1_hready1), .m1_hresp1(m1_hresp1),
    .smc_hsel1(smc_hsel1), .smc_haddr1(smc_haddr1), .smc_htrans1(smc_htrans1),
    .smc_hwrite1(smc_hwrite1), .smc_hsize1(smc_hsize1), .smc_hwdata1(smc_hwdata1),
    .smc_hready_in1(smc_hready_in1), .smc_hrdata1(smc_hrdata1),
    .smc_hready1(smc_hready1), .smc_hresp1(smc_hresp1), .arb_grant1(arb_grant1)
  );

  smc_ahb_arbiter1 #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
    .hclk1(clk), .n_sys_reset1(n_sys_reset1),
    .m0_hsel1(m0_hsel1), .m0_haddr1(m0_haddr1), .m0_htrans1(m0_htrans1),
    .m0_hwrite1(m0_hwrite1), .m0_hsize1(m0_hsize1), .m0_hwdata1(m0_hwdata1),
    .m0_hrdata1(fp_m0_hrdata1), .m0_hready1(fp_m0_hready1), .m0_hresp1(fp_m0_hresp1),
    .m1_hsel1(m1_hsel1), .m1_haddr1(m1_haddr1), .m1_htrans1(m1_htrans1),
    .m1_hwrite1(m1_hwrite1), .m1_hsize1(m1_hsize1), .m1_hwdata1(m1_hwdata1),
    .m1_hrdata1(fp_m1_hrdata1), .m1_hready1(fp_m1_hready1), .m1_hresp1(fp_m1_hresp1),
    .smc_hsel1(fp_smc_hsel1), .smc_haddr1(fp_smc_haddr1), .smc_htrans1(fp_smc_htrans1),
    .smc_hwrite1(fp_smc_hwrite1), .smc_hsize1(fp_smc_hsize1), .smc_hwdata1(fp_smc_hwdata1),
    .smc_hready_in1(fp_smc_hready_in1), .smc_hrdata1(smc_hrdata1),
    .smc_hready1(smc_hready1), .smc_hresp1(smc_hresp1), .arb_grant1(fp_arb_grant1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive just after the rising edge, sample on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic mreq(input int m, input logic wr, input logic [31:0] a);
    if (m == 0) begin
      m0_hsel1 = 1'b1; m0_htrans1 = HTRANS_NONSEQ; m0_hwrite1 = wr; m0_haddr1 = a; m0_hsize1 = 3'd2;
    end else begin
      m1_hsel1 = 1'b1; m1_htrans1 = HTRANS_NONSEQ; m1_hwrite1 = wr; m1_haddr1 = a; m1_hsize1 = 3'd2;
    end
  endtask

  task automatic midle(input int m);
    if (m == 0) begin
      m0_hsel1 = 1'b0; m0_htrans1 = HTRANS_IDLE;
    end else begin
      m1_hsel1 = 1'b0; m1_htrans1 = HTRANS_IDLE;
    end
  endtask

  task automatic smc(input logic rdy, input logic [1:0] rsp, input logic [31:0] rd);
    smc_hready1 = rdy; smc_hresp1 = rsp; smc_hrdata1 = rd;
  endtask

  initial begin
    n_sys_reset1 = 1'b0;
    m0_hsel1 = 0; m0_haddr1 = '0; m0_htrans1 = HTRANS_IDLE; m0_hwrite1 = 0; m0_hsize1 = '0; m0_hwdata1 = '0;
    m1_hsel1 = 0; m1_haddr1 = '0; m1_htrans1 = HTRANS_IDLE; m1_hwrite1 = 0; m1_hsize1 = '0; m1_hwdata1 = '0;
    smc(1'b1, HRESP_OKAY, 32'h0);

    // 1: reset values, then uncontended m0 read with one SMC wait state
    #12;
    chk("rst_m0_hready", m0_hready1, 1);
    chk("rst_m1_hready", m1_hready1, 1);
    chk("rst_m0_hresp", m0_hresp1, HRESP_OKAY);
    chk("rst_m0_hrdata", m0_hrdata1, 0);
    chk("rst_smc_hsel", smc_hsel1, 0);
    chk("rst_smc_htrans", smc_htrans1, HTRANS_IDLE);
    chk("rst_smc_haddr", smc_haddr1, 0);
    chk("rst_smc_hwdata", smc_hwdata1, 0);
    chk("rst_grant", arb_grant1, 0);
    chk("rst_hready_in", smc_hready_in1, 1);
    @(negedge clk); n_sys_reset1 = 1'b1;

    cyc(); mreq(0, 1'b0, 32'h100); smp();
    chk("t1_m0_accept", m0_hready1, 1);
    cyc(); midle(0); smp();
    chk("t1_smc_htrans", smc_htrans1, HTRANS_NONSEQ);
    chk("t1_smc_hsel", smc_hsel1, 1);
    chk("t1_smc_haddr", smc_haddr1, 32'h100);
    chk("t1_smc_hwrite", smc_hwrite1, 0);
    chk("t1_grant", arb_grant1, 2'b01);
    chk("t1_m0_stall1", m0_hready1, 0);
    cyc(); smc(1'b0, HRESP_OKAY, 32'h0); smp();
    chk("t1_data_htrans", smc_htrans1, HTRANS_IDLE);
    chk("t1_m0_stall2", m0_hready1, 0);
    cyc(); smc(1'b1, HRESP_OKAY, 32'hCAFE0100); smp();
    chk("t1_m0_done", m0_hready1, 1);
    chk("t1_m0_hrdata", m0_hrdata1, 32'hCAFE0100);
    chk("t1_m0_hresp", m0_hresp1, HRESP_OKAY);
    chk("t1_m1_hrdata", m1_hrdata1, 0);
    cyc(); smc(1'b1, HRESP_OKAY, 32'h0); smp();
    chk("t1_idle_grant", arb_grant1, 0);
    chk("t1_m0_idle_hrdata", m0_hrdata1, 0);

    // 2: simultaneous writes, round robin versus fixed priority
    @(negedge clk); n_sys_reset1 = 1'b0;
    #2; n_sys_reset1 = 1'b1;
    cyc(); mreq(0, 1'b1, 32'h10); mreq(1, 1'b1, 32'h20); smp();
    chk("t2_m0_accept", m0_hready1, 1);
    chk("t2_m1_accept", m1_hready1, 1);
    cyc(); midle(0); midle(1); m0_hwdata1 = 32'hD0; m1_hwdata1 = 32'hD1; smp();
    chk("t2_grant0", arb_grant1, 2'b01);
    chk("t2_addr0", smc_haddr1, 32'h10);
    chk("t2_write0", smc_hwrite1, 1);
    chk("t2_m1_stall", m1_hready1, 0);
    cyc(); smp();
    chk("t2_wdata0", smc_hwdata1, 32'hD0);
    chk("t2_m0_done", m0_hready1, 1);
    chk("t2_m1_stall2", m1_hready1, 0);
    chk("t2_m1_stall_hrdata", m1_hrdata1, 0);
    cyc(); smp();
    chk("t2_grant1", arb_grant1, 2'b10);
    chk("t2_addr1", smc_haddr1, 32'h20);
    chk("t2_m0_free", m0_hready1, 1);
    cyc(); smp();
    chk("t2_wdata1", smc_hwdata1, 32'hD1);
    chk("t2_m1_done", m1_hready1, 1);
    cyc(); mreq(0, 1'b0, 32'h30); smp();
    cyc(); midle(0); smp();
    chk("t2_lone_addr", smc_haddr1, 32'h30);
    cyc(); smp();
    chk("t2_lone_done", m0_hready1, 1);
    cyc(); mreq(0, 1'b1, 32'h40); mreq(1, 1'b1, 32'h50); smp();
    cyc(); midle(0); midle(1); m0_hwdata1 = 32'hE0; m1_hwdata1 = 32'hE1; smp();
    chk("t2_rr_grant_a", arb_grant1, 2'b10);
    chk("t2_rr_addr_a", smc_haddr1, 32'h50);
    chk("t2_fp_grant_a", fp_arb_grant1, 2'b01);
    chk("t2_fp_addr_a", fp_smc_haddr1, 32'h40);
    cyc(); smp();
    chk("t2_rr_wdata_a", smc_hwdata1, 32'hE1);
    chk("t2_fp_wdata_a", fp_smc_hwdata1, 32'hE0);
    cyc(); smp();
    chk("t2_rr_grant_b", arb_grant1, 2'b01);
    chk("t2_fp_grant_b", fp_arb_grant1, 2'b10);
    cyc(); smp();
    chk("t2_rr_wdata_b", smc_hwdata1, 32'hE0);
    chk("t2_fp_wdata_b", fp_smc_hwdata1, 32'hE1);
    cyc(); smp();
    chk("t2_rr_idle", arb_grant1, 0);
    chk("t2_fp_idle", fp_arb_grant1, 0);

    // 3: m1 read with three SMC wait states, m0 captured during the wait
    cyc(); mreq(1, 1'b0, 32'h200); smp();
    cyc(); midle(1); smp();
    chk("t3_grant_m1", arb_grant1, 2'b10);
    chk("t3_htrans", smc_htrans1, HTRANS_NONSEQ);
    cyc(); smc(1'b0, HRESP_OKAY, 32'h0); mreq(0, 1'b0, 32'h300); smp();
    chk("t3_m1_wait1", m1_hready1, 0);
    chk("t3_m0_accept", m0_hready1, 1);
    cyc(); midle(0); smp();
    chk("t3_m1_wait2", m1_hready1, 0);
    chk("t3_m0_stall", m0_hready1, 0);
    cyc(); smp();
    chk("t3_m1_wait3", m1_hready1, 0);
    chk("t3_grant_hold", arb_grant1, 2'b10);
    cyc(); smc(1'b1, HRESP_OKAY, 32'h11112222); smp();
    chk("t3_m1_done", m1_hready1, 1);
    chk("t3_m1_hrdata", m1_hrdata1, 32'h11112222);
    chk("t3_m0_hrdata", m0_hrdata1, 0);
    chk("t3_m0_stall2", m0_hready1, 0);
    cyc(); smc(1'b1, HRESP_OKAY, 32'h0); smp();
    chk("t3_grant_m0", arb_grant1, 2'b01);
    chk("t3_addr_m0", smc_haddr1, 32'h300);
    cyc(); smc(1'b1, HRESP_OKAY, 32'h33334444); smp();
    chk("t3_m0_done", m0_hready1, 1);
    chk("t3_m0_rdata", m0_hrdata1, 32'h33334444);

    // 4: two-cycle ERROR on an m0 write; m1 request queued meanwhile
    cyc(); smc(1'b1, HRESP_OKAY, 32'h0); mreq(0, 1'b1, 32'h400); smp();
    cyc(); midle(0); m0_hwdata1 = 32'hBAD; smp();
    chk("t4_grant_m0", arb_grant1, 2'b01);
    cyc(); smc(1'b0, HRESP_ERROR, 32'h0); mreq(1, 1'b0, 32'h500); smp();
    chk("t4_err1_resp", m0_hresp1, HRESP_ERROR);
    chk("t4_err1_ready", m0_hready1, 0);
    chk("t4_m1_resp1", m1_hresp1, HRESP_OKAY);
    chk("t4_m1_accept", m1_hready1, 1);
    cyc(); smc(1'b1, HRESP_ERROR, 32'h0); midle(1); smp();
    chk("t4_err2_resp", m0_hresp1, HRESP_ERROR);
    chk("t4_err2_ready", m0_hready1, 1);
    chk("t4_m1_stall", m1_hready1, 0);
    chk("t4_m1_resp2", m1_hresp1, HRESP_OKAY);
    cyc(); smc(1'b1, HRESP_OKAY, 32'h0); smp();
    chk("t4_grant_m1", arb_grant1, 2'b10);
    chk("t4_m0_resp_ok", m0_hresp1, HRESP_OKAY);
    chk("t4_m0_ready", m0_hready1, 1);
    cyc(); smc(1'b1, HRESP_OKAY, 32'h55); smp();
    chk("t4_m1_done", m1_hready1, 1);
    chk("t4_m1_rdata", m1_hrdata1, 32'h55);

    // 5: m0 back-to-back with m1 always requesting -> strict alternation
    cyc(); smc(1'b1, HRESP_OKAY, 32'h0); mreq(0, 1'b1, 32'h600); mreq(1, 1'b1, 32'h700); smp();
    cyc(); m0_hwdata1 = 32'h6000; m1_hwdata1 = 32'h7000; mreq(0, 1'b1, 32'h604); mreq(1, 1'b1, 32'h704); smp();
    chk("t5_g0", arb_grant1, 2'b01);
    chk("t5_a0", smc_haddr1, 32'h600);
    chk("t5_m0_stall", m0_hready1, 0);
    cyc(); smp();
    chk("t5_d0", smc_hwdata1, 32'h6000);
    chk("t5_m0_ready", m0_hready1, 1);
    chk("t5_m1_stall", m1_hready1, 0);
    cyc(); m0_hwdata1 = 32'h6004; midle(0); smp();
    chk("t5_g1", arb_grant1, 2'b10);
    chk("t5_a1", smc_haddr1, 32'h700);
    cyc(); smp();
    chk("t5_d1", smc_hwdata1, 32'h7000);
    chk("t5_m1_ready", m1_hready1, 1);
    cyc(); m1_hwdata1 = 32'h7004; midle(1); smp();
    chk("t5_g2", arb_grant1, 2'b01);
    chk("t5_a2", smc_haddr1, 32'h604);
    cyc(); smp();
    chk("t5_d2", smc_hwdata1, 32'h6004);
    cyc(); smp();
    chk("t5_g3", arb_grant1, 2'b10);
    chk("t5_a3", smc_haddr1, 32'h704);
    cyc(); smp();
    chk("t5_d3", smc_hwdata1, 32'h7004);
    cyc(); smp();
    chk("t5_idle", arb_grant1, 0);

    // 6: reset during the data phase of an m1 write with m0 pending
    cyc(); mreq(1, 1'b1, 32'h800); smp();
    cyc(); midle(1); m1_hwdata1 = 32'h8888; mreq(0, 1'b0, 32'h900); smp();
    chk("t6_grant_m1", arb_grant1, 2'b10);
    chk("t6_m0_accept", m0_hready1, 1);
    cyc(); midle(0); smc(1'b0, HRESP_OKAY, 32'h0); smp();
    chk("t6_m1_wait", m1_hready1, 0);
    chk("t6_m0_stall", m0_hready1, 0);
    chk("t6_wdata", smc_hwdata1, 32'h8888);
    #1 n_sys_reset1 = 1'b0;
    #1;
    chk("t6_rst_grant", arb_grant1, 0);
    chk("t6_rst_hsel", smc_hsel1, 0);
    chk("t6_rst_htrans", smc_htrans1, HTRANS_IDLE);
    chk("t6_rst_hwdata", smc_hwdata1, 0);
    chk("t6_rst_m0_ready", m0_hready1, 1);
    chk("t6_rst_m1_ready", m1_hready1, 1);
    @(negedge clk); n_sys_reset1 = 1'b1; smc(1'b1, HRESP_OKAY, 32'h0);
    cyc(); smp();
    chk("t6_pend_cleared", arb_grant1, 0);
    cyc(); mreq(0, 1'b0, 32'hA00); smp();
    cyc(); midle(0); smp();
    chk("t6_post_grant", arb_grant1, 2'b01);
    chk("t6_post_addr", smc_haddr1, 32'hA00);
    cyc(); smc(1'b1, HRESP_OKAY, 32'hA5A5); smp();
    chk("t6_post_done", m0_hready1, 1);
    chk("t6_post_rdata", m0_hrdata1, 32'hA5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
